// File: rtl/sar_pkg.sv
// Shared definitions for the SAR controller: state encoding and step weight table.
// step_weight() is the only source of DAC step weights for every SAR instance.
package sar_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SAMPLE,
    S_STROBE,
    S_WAIT,
    S_DONE
  } sar_state_e;

  localparam int RED_NBITS  = 12;
  localparam int RED_NSTEPS = 14;

  // Sub-radix-2 table; entries sum to 4095 so the accumulator never overflows.
  localparam int unsigned RED_W [RED_NSTEPS] = '{
    1536, 1024, 640, 384, 224, 128, 72, 40, 22, 12, 6, 4, 2, 1
  };

  function automatic int unsigned step_weight(input int mode, input int nbits,
                                              input int nsteps, input int idx);
    int unsigned w;
    w = 0;
    if (idx >= 0 && idx < nsteps) begin
      if (mode == 0)
        w = 32'd1 << (nbits - 1 - idx);
      else if (idx < RED_NSTEPS)
        w = RED_W[idx];
    end
    return w;
  endfunction

endpackage

// File: rtl/sar_step_timer.sv
// Down-counter shared by the sample window and the comparator wait.
// tc is high while the count sits at zero; load takes priority over counting.
module sar_step_timer #(
  parameter int W = 3
) (
  input  logic         clkin,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         tc
);

  logic [W-1:0] cnt;

  always_ff @(posedge clkin or negedge rst) begin
    if (!rst)
      cnt <= '0;
    else if (load)
      cnt <= load_val;
    else if (cnt != '0)
      cnt <= cnt - 1'b1;
  end

  assign tc = (cnt == '0);

endmodule

// File: rtl/sar_ctrl_param.sv
// Parametrised SAR conversion controller: sample, strobe/wait per step, done.
// Exports the final code and the raw MSB-first decision bits for calibration.
module sar_ctrl_param
  import sar_pkg::*;
#(
  parameter int NBITS         = 12,
  parameter int NSTEPS        = 14,
  parameter int STEP_MODE     = 1,
  parameter int SAMPLE_CYCLES = 4,
  parameter int COMP_LAT      = 1
) (
  input  logic              clkin,
  input  logic              rst,
  input  logic              start,
  input  logic              cont,
  input  logic              abort,
  output logic              sample,
  output logic              comp_strobe,
  input  logic              comp_in,
  output logic [NBITS-1:0]  dac_value,
  output logic              busy,
  output logic              done,
  output logic [NBITS-1:0]  result,
  output logic [NSTEPS-1:0] dec_bits
);

  localparam int PW   = (NSTEPS > 1) ? $clog2(NSTEPS) : 1;
  localparam int TMAX = (SAMPLE_CYCLES > COMP_LAT) ? SAMPLE_CYCLES : COMP_LAT;
  localparam int TW   = $clog2(TMAX + 1);

  if (STEP_MODE == 0 && NSTEPS != NBITS) begin : g_err_bin
    $error("sar_ctrl_param: binary weighting needs NSTEPS == NBITS");
  end
  if (STEP_MODE != 0 && (NBITS != RED_NBITS || NSTEPS != RED_NSTEPS)) begin : g_err_red
    $error("sar_ctrl_param: redundant table only defined for 12 bits / 14 steps");
  end
  if (SAMPLE_CYCLES < 1 || COMP_LAT < 1) begin : g_err_tim
    $error("sar_ctrl_param: SAMPLE_CYCLES and COMP_LAT must be >= 1");
  end

  sar_state_e        state;
  logic [NBITS-1:0]  acc;
  logic [PW-1:0]     ptr;
  logic [NSTEPS-1:0] shreg;
  logic [NSTEPS-1:0] shreg_nxt;
  logic [NBITS-1:0]  w_cur;
  logic [NBITS-1:0]  acc_add;
  logic              tload;
  logic [TW-1:0]     tval;
  logic              tc;

  assign w_cur     = NBITS'(step_weight(STEP_MODE, NBITS, NSTEPS, int'(ptr)));
  assign acc_add   = acc + w_cur;
  assign dac_value = acc_add;
  assign shreg_nxt = {shreg[NSTEPS-2:0], comp_in};

  // Timer is (re)loaded on every entry into SAMPLE or WAIT.
  always_comb begin
    tload = 1'b0;
    tval  = TW'(SAMPLE_CYCLES - 1);
    if (!abort) begin
      if ((state == S_IDLE && start) || (state == S_DONE && cont)) begin
        tload = 1'b1;
      end else if (state == S_STROBE) begin
        tload = 1'b1;
        tval  = TW'(COMP_LAT - 1);
      end
    end
  end

  sar_step_timer #(.W(TW)) u_timer (
    .clkin    (clkin),
    .rst      (rst),
    .load     (tload),
    .load_val (tval),
    .tc       (tc)
  );

  always_ff @(posedge clkin or negedge rst) begin
    if (!rst) begin
      state       <= S_IDLE;
      acc         <= '0;
      ptr         <= '0;
      shreg       <= '0;
      sample      <= 1'b0;
      comp_strobe <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      result      <= '0;
      dec_bits    <= '0;
    end else begin
      comp_strobe <= 1'b0;
      done        <= 1'b0;
      if (abort) begin
        state  <= S_IDLE;
        sample <= 1'b0;
        busy   <= 1'b0;
        acc    <= '0;
        ptr    <= '0;
      end else begin
        case (state)
          S_IDLE: if (start) begin
            state  <= S_SAMPLE;
            sample <= 1'b1;
            busy   <= 1'b1;
            acc    <= '0;
            ptr    <= '0;
            shreg  <= '0;
          end
          S_SAMPLE: if (tc) begin
            state       <= S_STROBE;
            sample      <= 1'b0;
            comp_strobe <= 1'b1;
          end
          S_STROBE: state <= S_WAIT;
          S_WAIT: if (tc) begin
            if (comp_in) acc <= acc_add;
            shreg <= shreg_nxt;
            if (ptr == PW'(NSTEPS - 1)) begin
              state    <= S_DONE;
              done     <= 1'b1;
              result   <= comp_in ? acc_add : acc;
              dec_bits <= shreg_nxt;
            end else begin
              ptr         <= ptr + 1'b1;
              state       <= S_STROBE;
              comp_strobe <= 1'b1;
            end
          end
          S_DONE: begin
            acc <= '0;
            ptr <= '0;
            if (cont) begin
              state  <= S_SAMPLE;
              sample <= 1'b1;
              shreg  <= '0;
            end else begin
              state <= S_IDLE;
              busy  <= 1'b0;
            end
          end
          default: begin
            state  <= S_IDLE;
            sample <= 1'b0;
            busy   <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
